// File: rtl/pwm_oc_pkg.sv
// Shared definitions for the multi-channel output-compare stage:
// deadtime FSM state encodings and the packed-bus slice helper.
package pwm_oc_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_LOW     = 2'd0,
    ST_DT_RISE = 2'd1,
    ST_HIGH    = 2'd2,
    ST_DT_FALL = 2'd3
  } oc_state_e;

  // Low bit index of channel k in a bus packed as NUM_CH slices of width w.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/pwm_oc_dtfsm.sv
// One deadtime FSM: turns a channel reference into a complementary
// main/comp pair with independent rise/fall deadtimes.
// main_q/comp_q are registered from the next state, so they line up with
// the state register and add no extra cycle of latency.
module pwm_oc_dtfsm
  import pwm_oc_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_psc_i,
  input  logic                rst_i,
  input  logic                ref_i,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  input  logic                out_en_i,
  input  logic                force_low_i,
  output logic                main_q,
  output logic                comp_q,
  output logic [ST_W-1:0]     state_o
);

  localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

  oc_state_e           state_q, state_n;
  logic [DT_WIDTH-1:0] dtcnt_q, dtcnt_n;

  assign state_o = state_q;

  // Next-state and deadtime counter; counter is loaded only on entry to a
  // deadtime state, so a deadtime change never shortens a running count.
  always_comb begin
    state_n = state_q;
    dtcnt_n = dtcnt_q;
    if (force_low_i) begin
      state_n = ST_LOW;
      dtcnt_n = '0;
    end else begin
      case (state_q)
        ST_LOW: begin
          if (ref_i) begin
            if (dt_rise_i == '0) begin
              state_n = ST_HIGH;
            end else begin
              state_n = ST_DT_RISE;
              dtcnt_n = dt_rise_i - DT_ONE;
            end
          end
        end
        ST_DT_RISE: begin
          if (!ref_i) begin
            state_n = ST_LOW;
          end else if (dtcnt_q == '0) begin
            state_n = ST_HIGH;
          end else begin
            dtcnt_n = dtcnt_q - DT_ONE;
          end
        end
        ST_HIGH: begin
          if (!ref_i) begin
            if (dt_fall_i == '0) begin
              state_n = ST_LOW;
            end else begin
              state_n = ST_DT_FALL;
              dtcnt_n = dt_fall_i - DT_ONE;
            end
          end
        end
        ST_DT_FALL: begin
          if (ref_i) begin
            state_n = ST_HIGH;
          end else if (dtcnt_q == '0) begin
            state_n = ST_LOW;
          end else begin
            dtcnt_n = dtcnt_q - DT_ONE;
          end
        end
        default: begin
          state_n = ST_LOW;
          dtcnt_n = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; outputs are gated by enable/break
  // while the FSM itself keeps tracking the reference.
  always_ff @(posedge clk_psc_i) begin
    if (rst_i) begin
      state_q <= ST_LOW;
      dtcnt_q <= '0;
      main_q  <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      dtcnt_q <= dtcnt_n;
      main_q  <= out_en_i && !force_low_i && (state_n == ST_HIGH);
      comp_q  <= out_en_i && !force_low_i && (state_n == ST_LOW);
    end
  end

endmodule

// File: rtl/pwm_oc_multi.sv
// NUM_CH-channel output-compare stage: shadowed compare window per channel,
// registered reference, deadtime FSM per channel, polarity XOR on the pins.
// Optional break latch is built only when PWM_OC_BREAK_EN is defined.
// fsm_state_o exposes every channel's FSM state (2 bits per channel).
module pwm_oc_multi
  import pwm_oc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int DT_WIDTH  = 8
) (
  input  logic                        clk_psc_i,
  input  logic                        rst_i,
  input  logic [CNT_WIDTH-1:0]        cnt_i,
  input  logic                        update_event_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cmp_start_pre_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0] cmp_end_pre_i,
  input  logic [NUM_CH*DT_WIDTH-1:0]  dt_rise_pre_i,
  input  logic [NUM_CH*DT_WIDTH-1:0]  dt_fall_pre_i,
  input  logic [NUM_CH-1:0]           mode_pre_i,
  input  logic [NUM_CH-1:0]           out_en_i,
  input  logic [NUM_CH-1:0]           main_pol_i,
  input  logic [NUM_CH-1:0]           comp_pol_i,
  input  logic                        break_i,
  input  logic                        break_clr_i,
  output logic [NUM_CH-1:0]           oc_main_o,
  output logic [NUM_CH-1:0]           oc_comp_o,
  output logic                        break_flag_o,
  output logic [NUM_CH*ST_W-1:0]      fsm_state_o
);

  logic [NUM_CH-1:0] main_q;
  logic [NUM_CH-1:0] comp_q;
  logic              force_low;

`ifdef PWM_OC_BREAK_EN
  logic break_flag_q;

  // Break latch: set has priority over clear.
  always_ff @(posedge clk_psc_i) begin
    if (rst_i) begin
      break_flag_q <= 1'b0;
    end else if (break_i) begin
      break_flag_q <= 1'b1;
    end else if (break_clr_i) begin
      break_flag_q <= 1'b0;
    end
  end

  // The raw input forces outputs off on the same edge that sets the flag.
  assign force_low    = break_i | break_flag_q;
  assign break_flag_o = break_flag_q;
`else
  logic unused_break;
  assign unused_break = break_i | break_clr_i;
  assign force_low    = 1'b0;
  assign break_flag_o = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_WIDTH-1:0] start_q;
    logic [CNT_WIDTH-1:0] end_q;
    logic [DT_WIDTH-1:0]  dt_rise_q;
    logic [DT_WIDTH-1:0]  dt_fall_q;
    logic                 mode_q;
    logic                 ref_q;

    // Shadow load on the update strobe; the compare uses the old values in
    // that same cycle. Reference is the unsigned half-open window, optionally
    // inverted.
    always_ff @(posedge clk_psc_i) begin
      if (rst_i) begin
        start_q   <= '0;
        end_q     <= '0;
        dt_rise_q <= '0;
        dt_fall_q <= '0;
        mode_q    <= 1'b0;
        ref_q     <= 1'b0;
      end else begin
        if (update_event_i) begin
          start_q   <= cmp_start_pre_i[slice_lo(k, CNT_WIDTH) +: CNT_WIDTH];
          end_q     <= cmp_end_pre_i[slice_lo(k, CNT_WIDTH) +: CNT_WIDTH];
          dt_rise_q <= dt_rise_pre_i[slice_lo(k, DT_WIDTH) +: DT_WIDTH];
          dt_fall_q <= dt_fall_pre_i[slice_lo(k, DT_WIDTH) +: DT_WIDTH];
          mode_q    <= mode_pre_i[k];
        end
        ref_q <= ((cnt_i >= start_q) && (cnt_i < end_q)) ^ mode_q;
      end
    end

    pwm_oc_dtfsm #(
      .DT_WIDTH(DT_WIDTH)
    ) u_dtfsm (
      .clk_psc_i  (clk_psc_i),
      .rst_i      (rst_i),
      .ref_i      (ref_q),
      .dt_rise_i  (dt_rise_q),
      .dt_fall_i  (dt_fall_q),
      .out_en_i   (out_en_i[k]),
      .force_low_i(force_low),
      .main_q     (main_q[k]),
      .comp_q     (comp_q[k]),
      .state_o    (fsm_state_o[slice_lo(k, ST_W) +: ST_W])
    );
  end

  // Pin polarity is applied combinationally after the registers.
  assign oc_main_o = main_q ^ main_pol_i;
  assign oc_comp_o = comp_q ^ comp_pol_i;

endmodule

// File: tb/tb_pwm_oc_multi.sv
// Directed bench for pwm_oc_multi. The driver pushes the hand-computed
// pin values for each clock into exp_q; the monitor pops and compares
// on every falling edge. Inputs change 1 time unit after the falling edge.
module tb_pwm_oc_multi;
  localparam int NUM_CH    = 4;
  localparam int CNT_WIDTH = 16;
  localparam int DT_WIDTH  = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        upd;
  logic [NUM_CH*CNT_WIDTH-1:0] start_pre;
  logic [NUM_CH*CNT_WIDTH-1:0] end_pre;
  logic [NUM_CH*DT_WIDTH-1:0]  dtr_pre;
  logic [NUM_CH*DT_WIDTH-1:0]  dtf_pre;
  logic [NUM_CH-1:0]           mode_pre;
  logic [NUM_CH-1:0]           out_en;
  logic [NUM_CH-1:0]           main_pol;
  logic [NUM_CH-1:0]           comp_pol;
  logic                        brk;
  logic                        brk_clr;
  logic [NUM_CH-1:0]           oc_main;
  logic [NUM_CH-1:0]           oc_comp;
  logic                        brk_flag;
  logic [NUM_CH*2-1:0]         fsm_state;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  // Clock
  always #5 clk = ~clk;

  pwm_oc_multi #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .DT_WIDTH(DT_WIDTH)
  ) dut (
    .clk_psc_i      (clk),
    .rst_i          (rst),
    .cnt_i          (cnt),
    .update_event_i (upd),
    .cmp_start_pre_i(start_pre),
    .cmp_end_pre_i  (end_pre),
    .dt_rise_pre_i  (dtr_pre),
    .dt_fall_pre_i  (dtf_pre),
    .mode_pre_i     (mode_pre),
    .out_en_i       (out_en),
    .main_pol_i     (main_pol),
    .comp_pol_i     (comp_pol),
    .break_i        (brk),
    .break_clr_i    (brk_clr),
    .oc_main_o      (oc_main),
    .oc_comp_o      (oc_comp),
    .break_flag_o   (brk_flag),
    .fsm_state_o    (fsm_state)
  );

  // Monitor: one expected entry per clock, compared away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      logic [8:0] got;
      string      nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {brk_flag, oc_main, oc_comp};
      chk_cnt++;
      if (got === e) pass_cnt++;
      else $display("FAIL %s: got flag=%b main=%b comp=%b, expected flag=%b main=%b comp=%b",
                    nm, got[8], got[7:4], got[3:0], e[8], e[7:4], e[3:0]);
    end
  end

  // Driver: one clock with expected pins after that edge (all channels equal).
  task automatic tkf(input logic m, input logic c, input logic f, input string nm);
    @(posedge clk);
    exp_q.push_back({f, {4{m}} ^ main_pol, {4{c}} ^ comp_pol});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic tk(input logic m, input logic c, input string nm);
    tkf(m, c, 1'b0, nm);
  endtask

  task automatic set_all(input int s, input int e, input int dr, input int df, input logic md);
    for (int k = 0; k < NUM_CH; k++) begin
      start_pre[k*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(s);
      end_pre[k*CNT_WIDTH +: CNT_WIDTH]   = CNT_WIDTH'(e);
      dtr_pre[k*DT_WIDTH +: DT_WIDTH]     = DT_WIDTH'(dr);
      dtf_pre[k*DT_WIDTH +: DT_WIDTH]     = DT_WIDTH'(df);
      mode_pre[k]                         = md;
    end
  endtask

  // Load preloads with one update pulse at cnt = 0.
  task automatic load(input int s, input int e, input int dr, input int df, input logic md,
                      input string nm);
    set_all(s, e, dr, df, md);
    upd = 1'b1;
    cnt = '0;
    tk(1'b0, 1'b1, nm);
    upd = 1'b0;
  endtask

  // Sweep cnt 0..30 with dt = 0: output after clock i reflects cnt i-1.
  task automatic sweep_window(input int lo, input int hi, input string nm);
    for (int i = 0; i <= 30; i++) begin
      logic m;
      cnt = CNT_WIDTH'(i);
      m   = (i >= lo) && (i <= hi);
      tk(m, !m, nm);
    end
  endtask

  initial begin
    rst = 1'b1; cnt = '0; upd = 1'b0;
    start_pre = '0; end_pre = '0; dtr_pre = '0; dtf_pre = '0; mode_pre = '0;
    out_en = '1; main_pol = 4'b0101; comp_pol = 4'b0000;
    brk = 1'b0; brk_clr = 1'b0;

    // Reset values follow the polarity inputs.
    tk(1'b0, 1'b0, "reset");
    tk(1'b0, 1'b0, "reset_hold");
    main_pol = 4'b0000;
    rst = 1'b0;
    tk(1'b0, 1'b1, "post_reset_low");
    chk_cnt++;
    if (fsm_state === 8'h00) pass_cnt++;
    else $display("FAIL fsm_state_low: got %h, expected 00", fsm_state);

    // Window 10..19, dt = 0: main high after clocks 11..20.
    load(10, 20, 0, 0, 1'b0, "win_load");
    sweep_window(11, 20, "window");

    // Comp polarity inversion on the pins.
    comp_pol = 4'hF;
    cnt = '0;
    tk(1'b0, 1'b1, "comp_pol");
    comp_pol = 4'h0;

    // Deadtime rise 3, fall 5.
    load(10, 20, 3, 5, 1'b0, "dt_load");
    for (int i = 0; i <= 30; i++) begin
      cnt = CNT_WIDTH'(i);
      if (i <= 10)      tk(1'b0, 1'b1, "dt_low");
      else if (i <= 13) tk(1'b0, 1'b0, "dt_rise_gap");
      else if (i <= 20) tk(1'b1, 1'b0, "dt_high");
      else if (i <= 25) tk(1'b0, 1'b0, "dt_fall_gap");
      else              tk(1'b0, 1'b1, "dt_low_again");
    end

    // Shadow: changed preload without update has no effect.
    load(10, 20, 0, 0, 1'b0, "sh_load");
    set_all(15, 20, 0, 0, 1'b0);
    sweep_window(11, 20, "shadow_hold");
    upd = 1'b1;
    cnt = '0;
    tk(1'b0, 1'b1, "sh_update");
    upd = 1'b0;
    sweep_window(16, 20, "shadow_new");

    // One-cycle reference with dt_rise = 4 aborts back to LOW.
    load(10, 11, 4, 0, 1'b0, "abort_load");
    for (int i = 0; i <= 20; i++) begin
      cnt = CNT_WIDTH'(i);
      if (i == 11) tk(1'b0, 1'b0, "abort_gap");
      else         tk(1'b0, 1'b1, "abort_low");
    end

    // Empty window.
    load(7, 7, 0, 0, 1'b0, "eq_load");
    for (int i = 0; i <= 15; i++) begin
      cnt = CNT_WIDTH'(i);
      tk(1'b0, 1'b1, "start_eq_end");
    end

    // Inverted mode.
    load(10, 20, 0, 0, 1'b1, "mode_load");
    for (int i = 0; i <= 30; i++) begin
      logic m;
      cnt = CNT_WIDTH'(i);
      m   = (i != 0) && !((i >= 11) && (i <= 20));
      tk(m, !m, "mode_inv");
    end

    // Output enable gates the registers, FSM stays HIGH.
    out_en = 4'h0;
    tk(1'b0, 1'b0, "out_en_off");
    out_en = 4'hF;
    tk(1'b1, 1'b0, "out_en_on");

    // Reset mid-operation.
    rst = 1'b1;
    tk(1'b0, 1'b0, "reset_mid");
    rst = 1'b0;
    tk(1'b0, 1'b1, "reset_release");

    // Bring channels to HIGH with cnt held at 15.
    set_all(10, 20, 0, 0, 1'b0);
    upd = 1'b1;
    cnt = CNT_WIDTH'(15);
    tk(1'b0, 1'b1, "brk_load");
    upd = 1'b0;
    tk(1'b0, 1'b1, "brk_prep1");
    tk(1'b1, 1'b0, "brk_prep2");

`ifdef PWM_OC_BREAK_EN
    brk = 1'b1;
    cnt = CNT_WIDTH'(25);
    tkf(1'b0, 1'b0, 1'b1, "break_set");
    brk_clr = 1'b1;
    tkf(1'b0, 1'b0, 1'b1, "break_clr_blocked");
    brk = 1'b0;
    tkf(1'b0, 1'b0, 1'b0, "break_clr");
    brk_clr = 1'b0;
    tkf(1'b0, 1'b1, 1'b0, "break_resume");
    tkf(1'b0, 1'b1, 1'b0, "break_resume2");
`else
    brk = 1'b1;
    brk_clr = 1'b1;
    tkf(1'b1, 1'b0, 1'b0, "break_ignored");
    tkf(1'b1, 1'b0, 1'b0, "break_ignored2");
    brk = 1'b0;
    brk_clr = 1'b0;
    tkf(1'b1, 1'b0, 1'b0, "break_idle");
`endif

    @(negedge clk);
    #1;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
